// File: rtl/soc_system_serial_capture.sv
// Serial capture block for the soc_system fabric.
// Samples serial_in on the selected edge of a software-toggled read clock, assembles
// DATA_WIDTH-bit words MSB-first and exposes data/status/control on an Avalon-MM slave.
module soc_system_serial_capture #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter bit          RESET_ENABLE = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        read_clk_in,
    input  logic        serial_in,
    output logic        irq
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    // Synchronisers; stage 3 of the read clock only exists for edge detection.
    logic rclk_s1_q, rclk_s2_q, rclk_s3_q;
    logic sin_s1_q, sin_s2_q;

    // Control register.
    logic enable_q, edge_sel_q, irq_en_q;

    // Capture state.
    state_e                state_q, state_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    logic                  wr, wr_status, wr_ctrl;
    logic                  clear_req, abort_req;
    logic                  edge_pulse, sample;
    logic [DATA_WIDTH-1:0] shifted;

    assign wr        = chipselect & ~write_n;
    assign wr_status = wr & (address == 2'd1);
    assign wr_ctrl   = wr & (address == 2'd2);
    assign clear_req = wr_status & writedata[0];
    assign abort_req = wr_status & writedata[1];

    // Selected transition between sync stages 2 and 3.
    assign edge_pulse = edge_sel_q ? (rclk_s3_q & ~rclk_s2_q) : (~rclk_s3_q & rclk_s2_q);
    assign sample     = edge_pulse & enable_q;
    assign shifted    = {sr_q[DATA_WIDTH-2:0], sin_s2_q};

    // Input synchronisers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rclk_s1_q <= 1'b0;
            rclk_s2_q <= 1'b0;
            rclk_s3_q <= 1'b0;
            sin_s1_q  <= 1'b0;
            sin_s2_q  <= 1'b0;
        end else begin
            rclk_s1_q <= read_clk_in;
            rclk_s2_q <= rclk_s1_q;
            rclk_s3_q <= rclk_s2_q;
            sin_s1_q  <= serial_in;
            sin_s2_q  <= sin_s1_q;
        end
    end

    // Control register writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= RESET_ENABLE;
            edge_sel_q <= 1'b0;
            irq_en_q   <= 1'b0;
        end else if (wr_ctrl) begin
            enable_q   <= writedata[0];
            edge_sel_q <= writedata[1];
            irq_en_q   <= writedata[2];
        end
    end

    // Capture FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            sr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Capture FSM next state: clear applies before completion, abort beats any edge.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        sr_d      = sr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (clear_req) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (abort_req) begin
            state_d = StIdle;
            count_d = '0;
            sr_d    = '0;
        end else if (sample) begin
            unique case (state_q)
                StIdle: begin
                    sr_d    = DATA_WIDTH'(sin_s2_q);
                    count_d = CntW'(1);
                    state_d = StShift;
                end
                StShift: begin
                    sr_d = shifted;
                    if (count_q == LastCnt) begin
                        data_d  = shifted;
                        count_d = '0;
                        valid_d = 1'b1;
                        // An unread word is being replaced, unless this cycle also clears.
                        if (valid_q && !clear_req) begin
                            overrun_d = 1'b1;
                        end
                        state_d = StIdle;
                    end else begin
                        count_d = count_q + CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Read mux, zero latency.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(data_q);
            2'd1:    readdata = {16'b0, 8'(count_q), 6'b0, overrun_q, valid_q};
            2'd2:    readdata = {29'b0, irq_en_q, edge_sel_q, enable_q};
            default: readdata = '0;
        endcase
    end

    assign irq = valid_q & irq_en_q;

endmodule

// File: tb/tb_soc_system_serial_capture.sv
// Self-checking bench for soc_system_serial_capture (DATA_WIDTH=8).
// Directed table, hand-written simultaneous-event sequences and a randomized phase
// checked against a queue-based model of the captured bit stream.
module tb_soc_system_serial_capture;

    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        read_clk_in;
    logic        serial_in;
    logic        irq;

    always #5 clk = ~clk;

    soc_system_serial_capture #(
        .DATA_WIDTH  (W),
        .RESET_ENABLE(1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .read_clk_in(read_clk_in),
        .serial_in  (serial_in),
        .irq        (irq)
    );

    int checks   = 0;
    int failures = 0;

    // Model: bits accepted since the last completed word, plus register contents.
    bit          mq[$];
    logic [31:0] m_data;
    bit          m_valid, m_overrun, m_enable, m_edge_sel, m_irq_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        mq.delete();
        m_data = '0; m_valid = 0; m_overrun = 0;
        m_enable = 0; m_edge_sel = 0; m_irq_en = 0;
    endfunction

    function automatic void m_bit(input bit b);
        logic [31:0] word;
        if (!m_enable) return;
        mq.push_back(b);
        if (mq.size() == W) begin
            word = 0;
            foreach (mq[i]) word = (word << 1) | 32'(mq[i]);
            if (m_valid) m_overrun = 1;
            m_valid = 1;
            m_data  = word;
            mq.delete();
        end
    endfunction

    function automatic void m_write(input logic [1:0] a, input logic [31:0] d);
        if (a == 2'd1) begin
            if (d[0]) begin m_valid = 0; m_overrun = 0; end
            if (d[1]) mq.delete();
        end else if (a == 2'd2) begin
            m_enable = d[0]; m_edge_sel = d[1]; m_irq_en = d[2];
        end
    endfunction

    function automatic logic [31:0] m_status();
        return (32'(mq.size()) << 8) | (32'(m_overrun) << 1) | 32'(m_valid);
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        m_write(a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1 d = readdata;
        chipselect = 1'b0;
    endtask

    // One full read-clock pulse carrying bit b: one rising and one falling edge.
    task automatic send_bit(input bit b);
        @(negedge clk);
        serial_in = b; read_clk_in = 1'b1;
        repeat (5) @(negedge clk);
        read_clk_in = 1'b0;
        repeat (5) @(negedge clk);
        m_bit(b);
    endtask

    task automatic send_bits(input int n, input logic [31:0] val);
        for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
    endtask

    // Rising read-clock edge whose pulse coincides with a bus write (rising mode only).
    task automatic edge_with_write(input bit b, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        serial_in = b; read_clk_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        repeat (3) @(negedge clk);
        read_clk_in = 1'b0;
        repeat (5) @(negedge clk);
        m_write(a, d);
        if (!(a == 2'd1 && d[1])) m_bit(b);
    endtask

    task automatic check_all(input string tag);
        logic [31:0] rd;
        bus_read(2'd0, rd); check({tag, " data"}, rd, m_data);
        bus_read(2'd1, rd); check({tag, " status"}, rd, m_status());
        bus_read(2'd2, rd);
        check({tag, " ctrl"}, rd, {29'b0, m_irq_en, m_edge_sel, m_enable});
        check({tag, " irq"}, 32'(irq), 32'(m_valid & m_irq_en));
    endtask

    typedef enum int {OpRd, OpWr, OpShift} op_e;
    typedef struct {
        op_e         op;
        logic [1:0]  addr;
        logic [31:0] data;
        int          nbits;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    function automatic vec_t mk(input op_e op, input logic [1:0] a, input logic [31:0] d,
                                input int n, input logic [31:0] e, input logic i);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.nbits = n; v.exp_rd = e; v.exp_irq = i;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        int          r;

        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; read_clk_in = 1'b0; serial_in = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Directed table: reset values, basic capture, overrun, abort, ignored addresses.
        vecs.push_back(mk(OpRd,    2'd2, 0,     0, 32'h0,    0));
        vecs.push_back(mk(OpRd,    2'd0, 0,     0, 32'h0,    0));
        vecs.push_back(mk(OpRd,    2'd1, 0,     0, 32'h0,    0));
        vecs.push_back(mk(OpRd,    2'd3, 0,     0, 32'h0,    0));
        vecs.push_back(mk(OpWr,    2'd2, 32'h1, 0, 0,        0));
        vecs.push_back(mk(OpShift, 2'd0, 32'hA5, 8, 0,       0));
        vecs.push_back(mk(OpRd,    2'd0, 0,     0, 32'hA5,   0));
        vecs.push_back(mk(OpRd,    2'd1, 0,     0, 32'h1,    0));
        vecs.push_back(mk(OpWr,    2'd2, 32'h5, 0, 0,        0));
        vecs.push_back(mk(OpRd,    2'd2, 0,     0, 32'h5,    1));
        vecs.push_back(mk(OpWr,    2'd1, 32'h1, 0, 0,        0));
        vecs.push_back(mk(OpRd,    2'd1, 0,     0, 32'h0,    0));
        vecs.push_back(mk(OpShift, 2'd0, 32'h3C, 8, 0,       0));
        vecs.push_back(mk(OpShift, 2'd0, 32'hC3, 8, 0,       0));
        vecs.push_back(mk(OpRd,    2'd0, 0,     0, 32'hC3,   1));
        vecs.push_back(mk(OpRd,    2'd1, 0,     0, 32'h3,    1));
        vecs.push_back(mk(OpWr,    2'd1, 32'h1, 0, 0,        0));
        vecs.push_back(mk(OpRd,    2'd1, 0,     0, 32'h0,    0));
        vecs.push_back(mk(OpShift, 2'd0, 32'h5, 3, 0,        0));
        vecs.push_back(mk(OpRd,    2'd1, 0,     0, 32'h300,  0));
        vecs.push_back(mk(OpWr,    2'd1, 32'h2, 0, 0,        0));
        vecs.push_back(mk(OpRd,    2'd1, 0,     0, 32'h0,    0));
        vecs.push_back(mk(OpShift, 2'd0, 32'hFF, 8, 0,       0));
        vecs.push_back(mk(OpRd,    2'd0, 0,     0, 32'hFF,   1));
        vecs.push_back(mk(OpRd,    2'd1, 0,     0, 32'h1,    1));
        vecs.push_back(mk(OpWr,    2'd3, 32'hFFFF_FFFF, 0, 0, 0));
        vecs.push_back(mk(OpRd,    2'd3, 0,     0, 32'h0,    1));
        vecs.push_back(mk(OpWr,    2'd0, 32'h12, 0, 0,       0));
        vecs.push_back(mk(OpRd,    2'd0, 0,     0, 32'hFF,   1));
        vecs.push_back(mk(OpWr,    2'd2, 32'h1, 0, 0,        0));
        vecs.push_back(mk(OpRd,    2'd2, 0,     0, 32'h1,    0));
        vecs.push_back(mk(OpWr,    2'd1, 32'h1, 0, 0,        0));
        vecs.push_back(mk(OpRd,    2'd1, 0,     0, 32'h0,    0));

        foreach (vecs[i]) begin
            unique case (vecs[i].op)
                OpWr:    bus_write(vecs[i].addr, vecs[i].data);
                OpShift: send_bits(vecs[i].nbits, vecs[i].data);
                OpRd: begin
                    bus_read(vecs[i].addr, rd);
                    check($sformatf("vec%0d readdata", i), rd, vecs[i].exp_rd);
                    check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
                end
                default: ;
            endcase
        end
        check_all("after table");

        // Clear in the same cycle as a completion with overrun pending.
        bus_write(2'd2, 32'h1);
        bus_write(2'd1, 32'h3);
        send_bits(8, 32'h11);
        send_bits(8, 32'h22);
        bus_read(2'd1, rd); check("overrun pending", rd, 32'h3);
        send_bits(7, 32'h19);
        edge_with_write(1'b1, 2'd1, 32'h1);
        bus_read(2'd1, rd); check("clear+completion status", rd, 32'h1);
        bus_read(2'd0, rd); check("clear+completion data", rd, 32'h33);

        // Abort in the same cycle as an edge: the edge is discarded.
        send_bits(3, 32'h6);
        edge_with_write(1'b1, 2'd1, 32'h2);
        bus_read(2'd1, rd); check("abort+edge status", rd, 32'h1);
        send_bits(8, 32'h81);
        bus_read(2'd0, rd); check("after abort data", rd, 32'h81);
        bus_read(2'd1, rd); check("after abort status", rd, 32'h3);
        check_all("abort seq");

        // Disabled edges are ignored and the word resumes; then repeat on falling edges.
        bus_write(2'd1, 32'h3);
        bus_write(2'd2, 32'h1);
        send_bits(4, 32'h9);
        bus_write(2'd2, 32'h0);
        repeat (5) send_bit(1'($urandom));
        bus_write(2'd2, 32'h1);
        send_bits(4, 32'h6);
        bus_read(2'd0, rd); check("enable gap rising data", rd, 32'h96);
        bus_read(2'd1, rd); check("enable gap rising status", rd, 32'h1);
        bus_write(2'd1, 32'h1);
        bus_write(2'd2, 32'h3);
        send_bits(4, 32'h9);
        bus_write(2'd2, 32'h2);
        repeat (5) send_bit(1'($urandom));
        bus_write(2'd2, 32'h3);
        send_bits(4, 32'h6);
        bus_read(2'd0, rd); check("enable gap falling data", rd, 32'h96);
        bus_read(2'd1, rd); check("enable gap falling status", rd, 32'h1);
        check_all("falling seq");

        // Reset mid-word with VALID set.
        bus_write(2'd2, 32'h5);
        send_bits(5, 32'h1F);
        bus_read(2'd1, rd); check("pre-reset status", rd, 32'h501);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        bus_read(2'd0, rd); check("post-reset data", rd, 32'h0);
        bus_read(2'd1, rd); check("post-reset status", rd, 32'h0);
        bus_read(2'd2, rd); check("post-reset ctrl", rd, 32'h0);
        check("post-reset irq", 32'(irq), 32'h0);
        bus_write(2'd2, 32'h1);
        send_bits(8, 32'h5A);
        bus_read(2'd0, rd); check("post-reset word", rd, 32'h5A);
        bus_read(2'd1, rd); check("post-reset word status", rd, 32'h1);

        // Randomized operations against the model.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                send_bit(1'($urandom));
            end else if (r < 70) begin
                bus_write(2'd2, {$urandom_range(0, 1) == 1, 1'($urandom),
                                 $urandom_range(0, 3) != 0} | ($urandom & 32'hFFFF_FFF8));
            end else if (r < 75) begin
                bus_write(2'd1, ($urandom & 32'hFFFF_FFFC) | 32'h1);
            end else if (r < 77) begin
                bus_write(2'd1, ($urandom & 32'hFFFF_FFFC) | 32'h2);
            end else if (r < 78) begin
                bus_write(2'd1, 32'h3);
            end else if (r < 80) begin
                bus_write(($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0, $urandom);
            end else begin
                check_all($sformatf("rand%0d", n));
            end
        end
        check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
